// File: rtl/sd_sector_uart_streamer.sv
// Captures one SD sector byte-serially into a local RAM, then replays it in
// address order to a UART transmitter over its data/strobe/busy handshake.
module sd_sector_uart_streamer #(
  parameter int DEPTH       = 512,
  parameter int ADDR_W      = 9,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  input  logic       sector_done,
  output logic       buf_busy,
  output logic [7:0] tx_data,
  output logic       tx_stb,
  input  logic       tx_busy,
  output logic       stream_done,
  output logic       overflow
);

  localparam int              TW      = $clog2(ACK_TIMEOUT + 1);
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE_C   = (ADDR_W + 1)'(1);

  typedef enum logic [2:0] {
    S_FILL, S_FETCH, S_LOAD, S_ISSUE, S_WAIT_ACK, S_WAIT_IDLE, S_NEXT
  } state_t;

  state_t          state_q;
  logic [ADDR_W:0] wr_ptr_q, rd_ptr_q, len_q;
  logic [TW-1:0]   tmr_q;
  logic            buf_busy_q, tx_stb_q, stream_done_q, overflow_q;
  logic [7:0]      tx_data_q, rdata_q;
  logic [7:0]      mem_q [DEPTH];

  logic            wr_ok_d;
  logic [ADDR_W:0] cnt_d;

  // Pointers and counts are one bit wider than the address so a full sector fits.
  always_comb begin
    wr_ok_d = (state_q == S_FILL) && wr_en && (wr_ptr_q < DEPTH_C);
    cnt_d   = wr_ptr_q + (ADDR_W + 1)'(wr_ok_d);
  end

  // RAM holds no reset; the read port is registered, so data lands one cycle after FETCH.
  always_ff @(posedge clk) begin
    if (wr_ok_d) mem_q[wr_ptr_q[ADDR_W-1:0]] <= wr_data;
    rdata_q <= mem_q[rd_ptr_q[ADDR_W-1:0]];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_FILL;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      len_q         <= '0;
      tmr_q         <= '0;
      buf_busy_q    <= 1'b0;
      tx_stb_q      <= 1'b0;
      tx_data_q     <= 8'h00;
      stream_done_q <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      tx_stb_q      <= 1'b0;
      stream_done_q <= 1'b0;
      if (state_q != S_FILL && (wr_en || sector_done)) overflow_q <= 1'b1;
      case (state_q)
        S_FILL: begin
          if (wr_ok_d)    wr_ptr_q   <= wr_ptr_q + ONE_C;
          else if (wr_en) overflow_q <= 1'b1;
          if (sector_done && cnt_d != '0) begin
            len_q      <= cnt_d;
            rd_ptr_q   <= '0;
            buf_busy_q <= 1'b1;
            state_q    <= S_FETCH;
          end
        end
        S_FETCH: state_q <= S_LOAD;
        S_LOAD: begin
          tx_data_q <= rdata_q;
          state_q   <= S_ISSUE;
        end
        S_ISSUE: begin
          if (!tx_busy) begin
            tx_stb_q <= 1'b1;
            tmr_q    <= '0;
            state_q  <= S_WAIT_ACK;
          end
        end
        S_WAIT_ACK: begin
          // A UART that never reports busy must not stall the stream forever.
          if (tx_busy)                              state_q <= S_WAIT_IDLE;
          else if (tmr_q == TW'(ACK_TIMEOUT - 1))   state_q <= S_NEXT;
          else                                      tmr_q   <= tmr_q + 1'b1;
        end
        S_WAIT_IDLE: if (!tx_busy) state_q <= S_NEXT;
        S_NEXT: begin
          if (rd_ptr_q == len_q - ONE_C) begin
            stream_done_q <= 1'b1;
            wr_ptr_q      <= '0;
            buf_busy_q    <= 1'b0;
            state_q       <= S_FILL;
          end else begin
            rd_ptr_q <= rd_ptr_q + ONE_C;
            state_q  <= S_FETCH;
          end
        end
        default: state_q <= S_FILL;
      endcase
    end
  end

  assign buf_busy    = buf_busy_q;
  assign tx_data     = tx_data_q;
  assign tx_stb      = tx_stb_q;
  assign stream_done = stream_done_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_sd_sector_uart_streamer.sv
// Bench for sd_sector_uart_streamer: table of sector scenarios plus a
// mid-stream reset sequence; transmitted bytes are checked against a queue.
module tb_sd_sector_uart_streamer;

  localparam int DEPTH = 512;

  logic       clk = 1'b0;
  logic       rst_n, wr_en, sector_done, tx_busy, uart_mute;
  logic [7:0] wr_data;
  logic       buf_busy, tx_stb, stream_done, overflow;
  logic [7:0] tx_data;

  sd_sector_uart_streamer #(.DEPTH(DEPTH), .ADDR_W(9), .ACK_TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data),
    .sector_done(sector_done), .buf_busy(buf_busy), .tx_data(tx_data),
    .tx_stb(tx_stb), .tx_busy(tx_busy), .stream_done(stream_done),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int stb_cnt = 0, done_cnt = 0, cyc = 0, last_stb = 0, interval = 0;
  bit busy_seen = 0;
  logic [7:0] exp_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // UART model: busy rises one cycle after the strobe and stays up 10 cycles.
  logic pend;
  int   bcnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend <= 1'b0; bcnt <= 0; tx_busy <= 1'b0;
    end else begin
      if (pend) begin
        tx_busy <= 1'b1; bcnt <= 10; pend <= 1'b0;
      end else if (bcnt > 1) bcnt <= bcnt - 1;
      else if (bcnt == 1) begin
        bcnt <= 0; tx_busy <= 1'b0;
      end
      if (tx_stb && !uart_mute) pend <= 1'b1;
    end
  end

  // Output monitor / scoreboard consumer.
  always @(negedge clk) begin
    cyc++;
    if (rst_n) begin
      if (buf_busy) busy_seen = 1;
      if (stream_done) done_cnt++;
      if (tx_stb) begin
        stb_cnt++;
        interval = cyc - last_stb;
        last_stb = cyc;
        if (exp_q.size() == 0) chk("unexpected_stb", 32'(tx_data), 32'hFFFF_FFFF);
        else chk("tx_data", 32'(tx_data), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0; wr_en = 1'b0; sector_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    exp_q.delete();
    stb_cnt = 0; done_cnt = 0; busy_seen = 0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_buf_busy", 32'(buf_busy), 0);
    chk("rst_tx_stb", 32'(tx_stb), 0);
    chk("rst_tx_data", 32'(tx_data), 0);
    chk("rst_stream_done", 32'(stream_done), 0);
    chk("rst_overflow", 32'(overflow), 0);
  endtask

  task automatic load_sector(input int n, input logic [7:0] base, input logic [7:0] step,
                             input bit coinc, input bit exp_ovf);
    logic [7:0] v;
    for (int i = 0; i < n; i++) begin
      v = base + 8'(i) * step;
      if (i < DEPTH) exp_q.push_back(v);
      @(posedge clk); #1;
      wr_en = 1'b1; wr_data = v; sector_done = coinc && (i == n - 1);
    end
    @(posedge clk); #1;
    wr_en = 1'b0; sector_done = 1'b0;
    if (!coinc) begin
      chk("fill_buf_busy", 32'(buf_busy), 0);
      chk("fill_overflow", 32'(overflow), 32'(exp_ovf));
      sector_done = 1'b1;
      @(posedge clk); #1;
      sector_done = 1'b0;
    end
  endtask

  task automatic wait_stream(input int exp_sent, input bit exp_ovf, input bit mute);
    int budget;
    budget = exp_sent * 40 + 200;
    if (exp_sent == 0) repeat (50) @(posedge clk);
    else begin
      while (done_cnt == 0 && budget > 0) begin
        @(posedge clk); budget--;
      end
      chk("done_in_time", 32'(done_cnt != 0), 1);
    end
    repeat (30) @(posedge clk);
    #1;
    chk("stb_count", 32'(stb_cnt), 32'(exp_sent));
    chk("done_count", 32'(done_cnt), 32'(exp_sent > 0));
    chk("queue_left", 32'(exp_q.size()), 0);
    chk("end_overflow", 32'(overflow), 32'(exp_ovf));
    chk("end_buf_busy", 32'(buf_busy), 0);
    chk("busy_seen", 32'(busy_seen), 32'(exp_sent > 0));
    if (mute) chk("timeout_interval", 32'(interval >= 19 && interval <= 20), 1);
  endtask

  typedef struct {
    int         n;
    logic [7:0] base, step;
    bit         coinc, mute;
    int         exp_sent;
    bit         exp_ovf;
  } vec_t;

  vec_t vecs[5];

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; wr_data = 8'h00; sector_done = 1'b0; uart_mute = 1'b0;
    vecs[0] = '{512, 8'h00, 8'h01, 1'b0, 1'b0, 512, 1'b0};
    vecs[1] = '{3,   8'hA1, 8'h11, 1'b1, 1'b0, 3,   1'b0};
    vecs[2] = '{513, 8'h00, 8'h01, 1'b0, 1'b0, 512, 1'b1};
    vecs[3] = '{0,   8'h00, 8'h00, 1'b0, 1'b0, 0,   1'b0};
    vecs[4] = '{4,   8'h10, 8'h01, 1'b0, 1'b1, 4,   1'b0};

    for (int k = 0; k < 5; k++) begin
      do_reset();
      uart_mute = vecs[k].mute;
      load_sector(vecs[k].n, vecs[k].base, vecs[k].step, vecs[k].coinc, vecs[k].exp_ovf);
      wait_stream(vecs[k].exp_sent, vecs[k].exp_ovf, vecs[k].mute);
    end

    // Reset after the 100th strobe of a full sector, then a fresh 2-byte sector.
    begin
      int budget, snap;
      do_reset();
      uart_mute = 1'b0;
      load_sector(512, 8'h00, 8'h01, 1'b0, 1'b0);
      budget = 5000;
      while (stb_cnt < 100 && budget > 0) begin
        @(posedge clk); #2; budget--;
      end
      chk("reach_100_stb", 32'(stb_cnt), 100);
      rst_n = 1'b0;
      #1;
      chk("midrst_tx_stb", 32'(tx_stb), 0);
      chk("midrst_buf_busy", 32'(buf_busy), 0);
      repeat (2) @(posedge clk);
      #1;
      exp_q.delete();
      snap = stb_cnt;
      rst_n = 1'b1;
      repeat (40) @(posedge clk);
      #1;
      chk("post_rst_no_stb", 32'(stb_cnt), 32'(snap));
      chk("post_rst_buf_busy", 32'(buf_busy), 0);
      chk("post_rst_overflow", 32'(overflow), 0);
      stb_cnt = 0; done_cnt = 0; busy_seen = 0;
      load_sector(2, 8'h5A, 8'h01, 1'b0, 1'b0);
      wait_stream(2, 1'b0, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sd_sector_uart_streamer.md
Name: sd_sector_uart_streamer

Overview:
- Buffers one SD sector, written byte-serially by the SD card reader, into an internal DEPTH x 8 RAM.
- When the reader signals end of sector, streams the buffered bytes in address order to the UART transmitter through its data/strobe/busy interface.
- Sits between the SD reader output and the UART `i_tx_data`/`i_tx_stb` inputs. Entirely in the system clock domain.

Parameters:
- DEPTH, 512: buffer size in bytes (one SD sector).
- ADDR_W, 9: address/count width; must satisfy 2^ADDR_W >= DEPTH.
- ACK_TIMEOUT, 15: cycles to wait for tx_busy to rise after a strobe before treating the byte as accepted.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- wr_en  in  1  byte-valid strobe from the SD reader.
- wr_data  in  8  byte from the SD reader.
- sector_done  in  1  one-cycle pulse: sector complete.
- buf_busy  out  1  high while not accepting writes (streaming).
- tx_data  out  8  byte to UART `i_tx_data`.
- tx_stb  out  1  one-cycle strobe to UART `i_tx_stb`.
- tx_busy  in  1  UART `o_tx_busy`.
- stream_done  out  1  one-cycle pulse after the last byte is accepted.
- overflow  out  1  sticky error flag.

Behaviour:
- Reset (async assert, sync release): state FILL, wr_ptr=0, rd_ptr=0, len=0.
  - Outputs: buf_busy=0, tx_stb=0, tx_data=8'h00, stream_done=0, overflow=0.
  - RAM contents are undefined after reset and are not cleared.
- RAM: one write port and one synchronous read port with 1-cycle read latency.
- FILL:
  - wr_en with wr_ptr<DEPTH: write to RAM[wr_ptr], then wr_ptr+1.
  - wr_en with wr_ptr==DEPTH: byte dropped, overflow<=1.
  - sector_done with effective count>0: len<=count, rd_ptr<=0, go to FETCH, buf_busy<=1 on the next cycle.
    - Effective count includes a same-cycle wr_en byte.
  - sector_done with effective count==0: ignored, stay in FILL.
- FETCH: drive RAM address rd_ptr, go to LOAD.
- LOAD: tx_data<=RAM output, go to ISSUE.
- ISSUE:
  - If tx_busy==0: tx_stb=1 for exactly this cycle, ack timer cleared, go to WAIT_ACK.
  - Otherwise hold in ISSUE with tx_stb=0.
- WAIT_ACK:
  - tx_busy==1: go to WAIT_IDLE.
  - ACK_TIMEOUT cycles elapsed with tx_busy low: treat the byte as accepted and go to NEXT.
- WAIT_IDLE: when tx_busy==0, go to NEXT.
- NEXT:
  - rd_ptr==len-1: stream_done=1 for one cycle, wr_ptr<=0, go to FILL (buf_busy<=0).
  - Otherwise rd_ptr+1, go to FETCH.
- tx_data holds its value from LOAD until the next LOAD; it is stable throughout the strobe and busy period.
- Minimum per-byte overhead is 4 cycles plus the UART busy time. No pipelining of the RAM read behind the UART.
- wr_en or sector_done outside FILL: ignored, overflow<=1; RAM and pointers unchanged.
- overflow clears only on reset.
- Partial sector (len<DEPTH): exactly len bytes are sent, RAM[0..len-1].
- Full sector: len=DEPTH is legal; the count register is ADDR_W+1 bits wide to hold DEPTH.
- Reset mid-stream: the stream aborts immediately, no further tx_stb, and the block returns to FILL.

Test Plan:
- Write 512 bytes (value = addr[7:0]), then pulse sector_done, with a UART model that raises busy 1 cycle after the strobe and holds it 10 cycles -> exactly 512 tx_stb pulses, tx_data sequence 00..FF,00..FF, one stream_done after the 512th, buf_busy high only during streaming, overflow=0.
- Write 3 bytes A1,B2,C3 with sector_done coincident with the C3 wr_en -> 3 strobes carrying A1,B2,C3, then stream_done.
- Write 513 bytes, then sector_done -> overflow=1 after the 513th; 512 bytes sent; the 513th value never appears.
- Pulse sector_done with no writes -> no tx_stb, state stays FILL, overflow=0.
- UART model that never raises tx_busy -> each byte advances after ACK_TIMEOUT=15 cycles; 4 bytes complete in bounded time with stream_done.
- Assert rst_n low after the 100th strobe of a 512-byte stream -> tx_stb stays 0, buf_busy=0, overflow=0. A subsequent 2-byte sector then streams correctly from address 0.
